ahblite_decoder_mux: RTL and testbench

Parametrised AHB-Lite address decoder plus slave-response multiplexer for the Cortex-M0 system bus. It takes the address-phase HADDR/HTRANS and produces one-hot slave selects from per-port base/mask windows. It registers the data-phase selection and muxes the slave HRDATA/HREADYOUT/HRESP back to the master. A built-in default slave returns a two-cycle AHB ERROR response to active transfers that hit no enabled window.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahblite_default_slave.sv | 73 +++++++
 rtl/ahblite_decoder_mux.sv | 100 ++++++++++
 tb/tb_ahblite_decoder_mux.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// Cortex-M0 system-bus decoder and its default slave.
package ahb_pkg;

  // HTRANS transfer types; bit 1 set means an active (NONSEQ/SEQ) transfer
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP response encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave states: ERR1 is the stalled first error cycle, ERR2 the
  // completing second cycle of the two-cycle AHB ERROR response
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for the AHB-Lite decoder: answers active transfers that hit no
// enabled window with a two-cycle ERROR response.
// Optional macro DECODER_ERR_CAPTURE_EN adds a sticky capture of the address
// of the first such error (err_valid/err_addr, cleared by err_clr).
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        def_sel,
  input  logic        hready,
`ifdef DECODER_ERR_CAPTURE_EN
  input  logic [31:0] haddr,
  input  logic        err_clr,
  output logic        err_valid,
  output logic [31:0] err_addr,
`endif
  output logic        ready,
  output logic        resp
);

  ds_state_t state;
  ds_state_t state_next;

  // State register; reset drops straight back to IDLE even mid-response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DS_IDLE;
    else        state <= state_next;
  end

  // Next-state and response outputs; ERR2 may chain into another ERR1 for a back-to-back error
  always_comb begin
    state_next = state;
    ready      = 1'b1;
    resp       = HRESP_OKAY;
    unique case (state)
      DS_IDLE: begin
        if (def_sel && hready) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        ready      = 1'b0;
        resp       = HRESP_ERROR;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        resp       = HRESP_ERROR;
        state_next = (def_sel && hready) ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

`ifdef DECODER_ERR_CAPTURE_EN
  logic capture;

  // A clear in the same cycle as a fresh error lets the new error be captured
  assign capture = (state == DS_IDLE) && def_sel && hready && (!err_valid || err_clr);

  // Sticky first-error capture; only the IDLE->ERR1 entry records an address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (capture) begin
      err_valid <= 1'b1;
      err_addr  <= haddr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder and slave-response multiplexer for the Cortex-M0
// system bus. Decodes HADDR[31:16] against per-port base/mask windows, keeps
// the data-phase selection, and muxes slave responses back to the master.
// Optional macro DECODER_ERR_CAPTURE_EN exposes the default slave's error
// address capture (err_clr, err_valid, err_addr).
module ahblite_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                        NUM_PORTS = 3,
  parameter logic [NUM_PORTS-1:0]      PORT_EN   = 3'b111,
  parameter logic [16*NUM_PORTS-1:0]   PORT_BASE = {16'h4000, 16'h2000, 16'h0000},
  parameter logic [16*NUM_PORTS-1:0]   PORT_MASK = {16'hFFFF, 16'hFFFF, 16'hFFFF}
)
(
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_PORTS-1:0]      HSEL_P,
  input  logic [NUM_PORTS*32-1:0]   HRDATA_P,
  input  logic [NUM_PORTS-1:0]      HREADYOUT_P,
  input  logic [NUM_PORTS-1:0]      HRESP_P,
`ifdef DECODER_ERR_CAPTURE_EN
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [31:0]               err_addr,
`endif
  output logic [31:0]               HRDATA,
  output logic                      HREADY,
  output logic                      HRESP
);

  logic [NUM_PORTS-1:0] hsel;
  logic                 found;
  logic                 def_sel;
  logic [NUM_PORTS:0]   sel_q;
  logic                 ds_ready;
  logic                 ds_resp;
  logic                 unused_bits;

  // Low address bits and HTRANS[0] play no part in decoding
  assign unused_bits = ^{HTRANS[0], HADDR[15:0]};

  // Window decode on HADDR only; the first (lowest-index) enabled hit wins so HSEL_P stays one-hot
  always_comb begin
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && PORT_EN[i] &&
          ((HADDR[31:16] & PORT_MASK[i*16 +: 16]) ==
           (PORT_BASE[i*16 +: 16] & PORT_MASK[i*16 +: 16]))) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign HSEL_P  = hsel;
  assign def_sel = !found && HTRANS[1];

  // Data-phase selection advances only when the bus is ready; held through wait states
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= {def_sel, hsel};
  end

  ahblite_default_slave u_default_slave (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .def_sel   (def_sel),
    .hready    (HREADY),
`ifdef DECODER_ERR_CAPTURE_EN
    .haddr     (HADDR),
    .err_clr   (err_clr),
    .err_valid (err_valid),
    .err_addr  (err_addr),
`endif
    .ready     (ds_ready),
    .resp      (ds_resp)
  );

  // Response mux; with nothing selected the bus idles ready with OKAY and zero data
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i]) begin
        HRDATA = HRDATA_P[i*32 +: 32];
        HREADY = HREADYOUT_P[i];
        HRESP  = HRESP_P[i];
      end
    end
    if (sel_q[NUM_PORTS]) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end
  end

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Self-checking bench for ahblite_decoder_mux: a default-parameter instance,
// an overlapping-window instance and a PORT_EN=3'b011 instance share stimulus.
// Error-capture checks are compiled when DECODER_ERR_CAPTURE_EN is defined.
module tb_ahblite_decoder_mux;
  import ahb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [95:0] HRDATA_P;
  logic [2:0]  HREADYOUT_P;
  logic [2:0]  HRESP_P;

  logic [2:0]  HSEL_P;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  logic [2:0]  ovl_hsel;
  logic [31:0] ovl_hrdata;
  logic        ovl_hready;
  logic        ovl_hresp;

  logic [2:0]  cap_hsel;
  logic [31:0] cap_hrdata;
  logic        cap_hready;
  logic        cap_hresp;

`ifdef DECODER_ERR_CAPTURE_EN
  logic        err_clr;
  logic        err_valid,     ovl_err_valid, cap_err_valid;
  logic [31:0] err_addr,      ovl_err_addr,  cap_err_addr;
`endif

  int errors;
  int checks;

  ahblite_decoder_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_P(HSEL_P), .HRDATA_P(HRDATA_P), .HREADYOUT_P(HREADYOUT_P), .HRESP_P(HRESP_P),
`ifdef DECODER_ERR_CAPTURE_EN
    .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
`endif
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  ahblite_decoder_mux #(.PORT_MASK({16'hFFFF, 16'h0000, 16'hFFFF})) dut_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_P(ovl_hsel), .HRDATA_P(HRDATA_P), .HREADYOUT_P(HREADYOUT_P), .HRESP_P(HRESP_P),
`ifdef DECODER_ERR_CAPTURE_EN
    .err_clr(err_clr), .err_valid(ovl_err_valid), .err_addr(ovl_err_addr),
`endif
    .HRDATA(ovl_hrdata), .HREADY(ovl_hready), .HRESP(ovl_hresp)
  );

  ahblite_decoder_mux #(.PORT_EN(3'b011)) dut_cap (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_P(cap_hsel), .HRDATA_P(HRDATA_P), .HREADYOUT_P(HREADYOUT_P), .HRESP_P(HRESP_P),
`ifdef DECODER_ERR_CAPTURE_EN
    .err_clr(err_clr), .err_valid(cap_err_valid), .err_addr(cap_err_addr),
`endif
    .HRDATA(cap_hrdata), .HREADY(cap_hready), .HRESP(cap_hresp)
  );

  // Free-running bus clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance to just after the next rising edge, where new inputs are driven
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HADDR   = 32'h6000_0000;
    HTRANS  = HTRANS_IDLE;
    tick();
    tick();
    HRESETn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    HRESETn     = 1'b0;
    HADDR       = 32'h6000_0000;
    HTRANS      = HTRANS_IDLE;
    HRDATA_P    = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    HREADYOUT_P = 3'b111;
    HRESP_P     = 3'b000;
`ifdef DECODER_ERR_CAPTURE_EN
    err_clr     = 1'b0;
`endif
    #2;
    tick();
    checks++; if (HSEL_P !== 3'b000) begin errors++; $display("[TB] FAIL reset_hsel got=%b exp=000", HSEL_P); end
    checks++; if (HREADY !== 1'b1) begin errors++; $display("[TB] FAIL reset_hready got=%b exp=1", HREADY); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp got=%b exp=0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata got=%h exp=00000000", HRDATA); end
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_map_hit();
    HADDR  = 32'h2000_0010;
    HTRANS = HTRANS_NONSEQ;
    #1;
    checks++; if (HSEL_P !== 3'b010) begin errors++; $display("[TB] FAIL map_hsel_port1 got=%b exp=010", HSEL_P); end
    tick();
    HADDR   = 32'h6000_0000;
    HTRANS  = HTRANS_IDLE;
    HRESP_P = 3'b010;
    #1;
    checks++; if (HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL map_hrdata_port1 got=%h exp=deadbeef", HRDATA); end
    checks++; if (HREADY !== 1'b1) begin errors++; $display("[TB] FAIL map_hready_port1 got=%b exp=1", HREADY); end
    checks++; if (HRESP !== 1'b1) begin errors++; $display("[TB] FAIL map_hresp_port1 got=%b exp=1", HRESP); end
    HADDR = 32'h0000_0000; #1;
    checks++; if (HSEL_P !== 3'b001) begin errors++; $display("[TB] FAIL map_hsel_port0 got=%b exp=001", HSEL_P); end
    HADDR = 32'h4000_1234; #1;
    checks++; if (HSEL_P !== 3'b100) begin errors++; $display("[TB] FAIL map_hsel_port2 got=%b exp=100", HSEL_P); end
    HADDR = 32'h2000_FFFF; #1;
    checks++; if (HSEL_P !== 3'b010) begin errors++; $display("[TB] FAIL map_hsel_idle_indep got=%b exp=010", HSEL_P); end
    HADDR = 32'h6000_0000; #1;
    checks++; if (HSEL_P !== 3'b000) begin errors++; $display("[TB] FAIL map_hsel_unmapped got=%b exp=000", HSEL_P); end
    tick();
    HRESP_P = 3'b000;
    #1;
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL map_hrdata_none got=%h exp=00000000", HRDATA); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("[TB] FAIL map_hresp_none got=%b exp=0", HRESP); end
  endtask

  task automatic test_wait_states();
    HADDR  = 32'h4000_0000;
    HTRANS = HTRANS_NONSEQ;
    tick();
    HREADYOUT_P = 3'b011;
    HADDR       = 32'h0000_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (HREADY !== 1'b0) begin errors++; $display("[TB] FAIL wait_hready_c%0d got=%b exp=0", c, HREADY); end
      checks++; if (HRDATA !== 32'h3333_3333) begin errors++; $display("[TB] FAIL wait_hrdata_c%0d got=%h exp=33333333", c, HRDATA); end
      if (c < 2) tick();
    end
    HREADYOUT_P = 3'b111;
    #1;
    checks++; if (HREADY !== 1'b1) begin errors++; $display("[TB] FAIL wait_release_hready got=%b exp=1", HREADY); end
    tick();
    HADDR  = 32'h6000_0000;
    HTRANS = HTRANS_IDLE;
    #1;
    checks++; if (HRDATA !== 32'h1111_1111) begin errors++; $display("[TB] FAIL wait_next_hrdata got=%h exp=11111111", HRDATA); end
    tick();
  endtask

  task automatic test_unmapped_nonseq();
    HADDR  = 32'h6000_0000;
    HTRANS = HTRANS_NONSEQ;
    #1;
    checks++; if (HSEL_P !== 3'b000) begin errors++; $display("[TB] FAIL err_hsel got=%b exp=000", HSEL_P); end
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL err_addr_phase got=%b exp=10", {HREADY, HRESP}); end
    tick();
    HADDR = 32'h6000_0100;
    #1;
    checks++; if ({HREADY, HRESP} !== 2'b01) begin errors++; $display("[TB] FAIL err_err1 got=%b exp=01", {HREADY, HRESP}); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL err_hrdata got=%h exp=00000000", HRDATA); end
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b11) begin errors++; $display("[TB] FAIL err_err2 got=%b exp=11", {HREADY, HRESP}); end
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    checks++; if ({HREADY, HRESP} !== 2'b01) begin errors++; $display("[TB] FAIL err_b2b_err1 got=%b exp=01", {HREADY, HRESP}); end
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b11) begin errors++; $display("[TB] FAIL err_b2b_err2 got=%b exp=11", {HREADY, HRESP}); end
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL err_abort_idle got=%b exp=10", {HREADY, HRESP}); end
  endtask

  task automatic test_unmapped_idle();
    HADDR  = 32'h6000_0000;
    HTRANS = HTRANS_IDLE;
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL idle_unmapped got=%b exp=10", {HREADY, HRESP}); end
    HTRANS = HTRANS_BUSY;
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL busy_unmapped got=%b exp=10", {HREADY, HRESP}); end
    HTRANS = HTRANS_IDLE;
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL busy_after got=%b exp=10", {HREADY, HRESP}); end
  endtask

  task automatic test_reset_mid();
    HADDR  = 32'h6000_0000;
    HTRANS = HTRANS_NONSEQ;
    tick();
    checks++; if (HREADY !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_err1 got=%b exp=0", HREADY); end
    HRESETn = 1'b0;
    #1;
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_async got=%b exp=10", {HREADY, HRESP}); end
    HTRANS = HTRANS_IDLE;
    tick();
    HRESETn = 1'b1;
    tick();
    checks++; if ({HREADY, HRESP} !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_after got=%b exp=10", {HREADY, HRESP}); end
  endtask

  task automatic test_overlap();
    HTRANS = HTRANS_IDLE;
    HADDR = 32'h2000_0000; #1;
    checks++; if (ovl_hsel !== 3'b010) begin errors++; $display("[TB] FAIL ovl_2000 got=%b exp=010", ovl_hsel); end
    HADDR = 32'h0000_0000; #1;
    checks++; if (ovl_hsel !== 3'b001) begin errors++; $display("[TB] FAIL ovl_0000 got=%b exp=001", ovl_hsel); end
    HADDR = 32'h4000_0000; #1;
    checks++; if (ovl_hsel !== 3'b010) begin errors++; $display("[TB] FAIL ovl_4000 got=%b exp=010", ovl_hsel); end
    HADDR = 32'h6000_0000; #1;
    checks++; if (ovl_hsel !== 3'b010) begin errors++; $display("[TB] FAIL ovl_6000 got=%b exp=010", ovl_hsel); end
    tick();
  endtask

  task automatic test_port_en_capture();
    do_reset();
    HADDR  = 32'h4000_0004;
    HTRANS = HTRANS_NONSEQ;
    #1;
    checks++; if (cap_hsel !== 3'b000) begin errors++; $display("[TB] FAIL cap_hsel_disabled got=%b exp=000", cap_hsel); end
    tick();
    HADDR = 32'h6000_0008;
    #1;
    checks++; if ({cap_hready, cap_hresp} !== 2'b01) begin errors++; $display("[TB] FAIL cap_err1 got=%b exp=01", {cap_hready, cap_hresp}); end
`ifdef DECODER_ERR_CAPTURE_EN
    checks++; if (cap_err_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_valid_set got=%b exp=1", cap_err_valid); end
    checks++; if (cap_err_addr !== 32'h4000_0004) begin errors++; $display("[TB] FAIL cap_addr got=%h exp=40000004", cap_err_addr); end
`endif
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    checks++; if ({cap_hready, cap_hresp} !== 2'b11) begin errors++; $display("[TB] FAIL cap_err2 got=%b exp=11", {cap_hready, cap_hresp}); end
    tick();
    HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    checks++; if ({cap_hready, cap_hresp} !== 2'b01) begin errors++; $display("[TB] FAIL cap_second_err1 got=%b exp=01", {cap_hready, cap_hresp}); end
`ifdef DECODER_ERR_CAPTURE_EN
    checks++; if (cap_err_addr !== 32'h4000_0004) begin errors++; $display("[TB] FAIL cap_no_overwrite got=%h exp=40000004", cap_err_addr); end
`endif
    tick();
    tick();
`ifdef DECODER_ERR_CAPTURE_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    checks++; if (cap_err_valid !== 1'b0) begin errors++; $display("[TB] FAIL cap_clear got=%b exp=0", cap_err_valid); end
    HADDR  = 32'h6000_000C;
    HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    #1;
    checks++; if ({cap_err_valid, cap_err_addr} !== {1'b1, 32'h6000_000C}) begin errors++; $display("[TB] FAIL cap_recapture got=%b/%h exp=1/6000000c", cap_err_valid, cap_err_addr); end
    tick();
    tick();
`endif
  endtask

  // Scenario sequence followed by the one summary line
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_map_hit();
    test_wait_states();
    test_unmapped_nonseq();
    test_unmapped_idle();
    test_reset_mid();
    test_overlap();
    test_port_en_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
